// File: rtl/bus_memory_responder_pkg.sv
// Shared bus widths, FSM state encoding and operation type for the LEGv8
// bus memory responder.
package bus_defs;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 64;
    localparam int WAIT_CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_WAIT = S_WAIT,
        ST_RESP = S_RESP
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/bus_memory_responder_if.sv
// Request/completion signals between the control unit (master) and the
// memory responder (slave). The shared 64-bit data bus is a separate inout net.
interface bus_memory_responder_if;
    import bus_defs::*;

    // Handshake: mem_read/mem_write are held by the master until ready=1 and
    // must then be dropped for at least one edge; err only has meaning while ready=1.
    logic [ADDR_W-1:0] address;
    logic              mem_read;
    logic              mem_write;
    logic              ready;
    logic              err;
    logic              busy;

    modport master (
        output address, mem_read, mem_write,
        input  ready, err, busy
    );

    modport slave (
        input  address, mem_read, mem_write,
        output ready, err, busy
    );

endinterface

// File: rtl/bus_memory_responder_ram.sv
// Single-port 64-bit word memory: synchronous write with enable, registered
// read that holds its value while read enable is low. The array is not reset.
module word_ram_64
    import bus_defs::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clock,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bus_memory_responder.sv
// Memory-mapped responder on the shared tristate buses: decodes an address
// window and serves one 64-bit word read or write after WAIT_STATES cycles.
module bus_memory_responder
    import bus_defs::*;
#(
    parameter int          ADDR_BITS   = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    bus_memory_responder_if.slave bus,
    inout  wire  [DATA_W-1:0]     data,
    output state_t                dbg_state
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

    state_t                state, state_n;
    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [ADDR_BITS-1:0]  idx_q, live_idx, c_idx;
    op_t                   op_q, live_op, c_op;
    logic                  err_q, live_err, c_err;
    logic [DATA_W-1:0]     wdata_q, c_data, rdata;
    logic                  sel, accept, held, commit;
    logic                  ram_we, ram_re, drive;

    assign live_idx = bus.address[2+ADDR_BITS:3];
    assign sel      = (bus.address[ADDR_W-1:3+ADDR_BITS] == BASE_ADDR[ADDR_W-1:3+ADDR_BITS]);
    assign live_op  = bus.mem_write ? OP_WRITE : OP_READ;
    assign live_err = (bus.address[2:0] != 3'd0) || (bus.mem_read && bus.mem_write);
    assign accept   = (state == ST_IDLE) && sel && (bus.mem_read || bus.mem_write);

    // The strobe being watched is the one for the latched op (write wins when both were high).
    assign held = (op_q == OP_WRITE) ? bus.mem_write : bus.mem_read;

    always_comb begin
        state_n = state;
        commit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_n = ST_WAIT;
                    end else begin
                        state_n = ST_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!held) begin
                    state_n = ST_IDLE;
                end else if (cnt_q == CNT_ONE) begin
                    state_n = ST_RESP;
                    commit  = 1'b1;
                end
            end
            ST_RESP: begin
                if (!held) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // With zero wait states the commit happens on the sampling edge itself,
    // so the live bus values are used instead of the not-yet-loaded latches.
    assign c_idx  = (state == ST_IDLE) ? live_idx : idx_q;
    assign c_op   = (state == ST_IDLE) ? live_op  : op_q;
    assign c_err  = (state == ST_IDLE) ? live_err : err_q;
    assign c_data = (state == ST_IDLE) ? data     : wdata_q;

    assign ram_we = commit && (c_op == OP_WRITE) && !c_err;
    assign ram_re = commit && (c_op == OP_READ) && !c_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            op_q    <= OP_READ;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                cnt_q   <= WAIT_LOAD;
                idx_q   <= live_idx;
                op_q    <= live_op;
                err_q   <= live_err;
                wdata_q <= data;
            end else if (state == ST_WAIT) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

    word_ram_64 #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (c_idx),
        .wdata (c_data),
        .rdata (rdata)
    );

    assign bus.ready = (state == ST_RESP);
    assign bus.err   = (state == ST_RESP) && err_q;
    assign bus.busy  = (state != ST_IDLE);
    assign dbg_state = state;

    // Combinational in mem_read so the bus is released the moment the requester lets go.
    assign drive = (state == ST_RESP) && (op_q == OP_READ) && bus.mem_read && !err_q;
    assign data  = drive ? rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_memory_responder.sv
// Bench for bus_memory_responder: one instance with two wait states and one
// with none, driven from shared request tasks and checked by per-instance monitors.
module tb_bus_memory_responder;
    import bus_defs::*;

    localparam int          AB   = 8;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [63:0] ALL1 = '1;

    typedef struct {
        logic        err;
        logic [63:0] bus;
        int          issue;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0] addr = '0;
    logic        rd   = 1'b0;
    logic        wr   = 1'b0;
    logic        drv  = 1'b0;
    logic [63:0] dval = '0;
    int          which = 0;

    tri1 [63:0] data_a;
    tri1 [63:0] data_b;
    state_t     st_a, st_b;

    bus_memory_responder_if bif_a ();
    bus_memory_responder_if bif_b ();

    assign bif_a.address   = addr;
    assign bif_a.mem_read  = rd && (which == 0);
    assign bif_a.mem_write = wr && (which == 0);
    assign bif_b.address   = addr;
    assign bif_b.mem_read  = rd && (which == 1);
    assign bif_b.mem_write = wr && (which == 1);
    assign data_a = (drv && which == 0) ? dval : 64'bz;
    assign data_b = (drv && which == 1) ? dval : 64'bz;

    bus_memory_responder #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .WAIT_STATES(2)) dut_a (
        .clock (clock), .reset (reset), .bus (bif_a.slave), .data (data_a), .dbg_state (st_a)
    );

    bus_memory_responder #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut_b (
        .clock (clock), .reset (reset), .bus (bif_b.slave), .data (data_b), .dbg_state (st_b)
    );

    int          checks = 0;
    int          passes = 0;
    exp_t        exp_a[$];
    exp_t        exp_b[$];
    logic [63:0] model [int];

    function automatic logic rdy_of(int k);
        return (k == 0) ? bif_a.ready : bif_b.ready;
    endfunction
    function automatic logic err_of(int k);
        return (k == 0) ? bif_a.err : bif_b.err;
    endfunction
    function automatic logic busy_of(int k);
        return (k == 0) ? bif_a.busy : bif_b.busy;
    endfunction
    function automatic logic [63:0] bus_of(int k);
        return (k == 0) ? data_a : data_b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    endtask

    // Monitors: every rising ready must match the oldest outstanding expectation.
    task automatic mon(input int k);
        exp_t e;
        int   lat_exp;
        lat_exp = (k == 0) ? 3 : 1;
        if ((k == 0 && exp_a.size() == 0) || (k == 1 && exp_b.size() == 0)) begin
            checks++;
            $display("FAIL unexpected_ready: dut %0d raised ready with no request outstanding (t=%0t)", k, $time);
        end else begin
            e = (k == 0) ? exp_a.pop_front() : exp_b.pop_front();
            chk("resp_err", 64'(err_of(k)), 64'(e.err));
            chk("resp_latency", 64'(cyc - e.issue), 64'(lat_exp));
            chk("resp_data", bus_of(k), e.bus);
        end
    endtask

    logic rdy_prev_a = 1'b0;
    logic rdy_prev_b = 1'b0;
    always @(negedge clock) begin
        if (bif_a.ready && !rdy_prev_a) mon(0);
        rdy_prev_a = bif_a.ready;
    end
    always @(negedge clock) begin
        if (bif_b.ready && !rdy_prev_b) mon(1);
        rdy_prev_b = bif_b.ready;
    end

    function automatic bit in_window(input logic [31:0] a);
        return (a >> (3 + AB)) == (BASE >> (3 + AB));
    endfunction

    // One request: records the expected response, holds strobes until ready
    // (plus 'extra' cycles), then drops them and checks release/clear.
    task automatic do_req(input int k, input logic [31:0] a, input bit r, input bit w,
                          input logic [63:0] d, input int extra);
        exp_t x;
        bit   s, e, got;
        int   key;
        s   = in_window(a);
        e   = (a[2:0] != 3'd0) || (r && w);
        key = k * 1024 + int'(a[2+AB:3]);
        @(negedge clock); #1;
        if (s) begin
            x.err   = e;
            x.issue = cyc;
            if (w) x.bus = d;
            else if (e) x.bus = ALL1;
            else x.bus = model.exists(key) ? model[key] : ALL1;
            if (k == 0) exp_a.push_back(x);
            else exp_b.push_back(x);
            if (!e && w) model[key] = d;
        end
        which = k; addr = a; rd = r; wr = w; dval = d; drv = w;
        if (s) begin
            got = 1'b0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(posedge clock); #1;
                got = rdy_of(k);
            end
            if (!got) begin
                checks++;
                $display("FAIL ready_timeout: dut %0d addr %h got no ready within 40 edges", k, a);
            end
            for (int i = 0; i < extra; i++) begin
                @(posedge clock); #1;
                chk("ready_held", 64'(rdy_of(k)), 64'(got));
            end
            @(negedge clock); #1;
            rd = 1'b0; wr = 1'b0; drv = 1'b0;
            #1 chk("bus_released", bus_of(k), ALL1);
            @(posedge clock); #1;
            chk("ready_cleared", 64'(rdy_of(k)), 64'd0);
            chk("err_cleared", 64'(err_of(k)), 64'd0);
        end else begin
            for (int i = 0; i < extra; i++) begin
                @(posedge clock); #1;
                chk("unsel_ready", 64'(rdy_of(k)), 64'd0);
                chk("unsel_busy", 64'(busy_of(k)), 64'd0);
                chk("unsel_bus", bus_of(k), w ? d : ALL1);
            end
            @(negedge clock); #1;
            rd = 1'b0; wr = 1'b0; drv = 1'b0;
        end
    endtask

    task automatic rand_ops(input int k, input int n);
        logic [31:0] a;
        logic [63:0] d;
        int          idx, t;
        for (int i = 0; i < n; i++) begin
            idx = $urandom_range(0, 15);
            t   = $urandom_range(0, 9);
            d   = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFE;
            a   = 32'(idx * 8);
            if (t == 0) do_req(k, a + 32'($urandom_range(1, 7)), 1'b1, 1'b0, d, 0);
            else if (t == 1) do_req(k, a, 1'b1, 1'b1, d, 0);
            else if (t == 2) do_req(k, a + 32'h800 * 32'($urandom_range(1, 100)), 1'b1, 1'b0, d, 2);
            else if (t <= 5 && model.exists(k * 1024 + idx)) do_req(k, a, 1'b1, 1'b0, d, 0);
            else do_req(k, a, 1'b0, 1'b1, d, 0);
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("reset_ready_a", 64'(bif_a.ready), 64'd0);
        chk("reset_err_a", 64'(bif_a.err), 64'd0);
        chk("reset_busy_a", 64'(bif_a.busy), 64'd0);
        chk("reset_bus_a", data_a, ALL1);
        chk("reset_busy_b", 64'(bif_b.busy), 64'd0);
        chk("reset_bus_b", data_b, ALL1);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;

        // Basic write then read-back, two wait states.
        do_req(0, 32'h10, 1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 0);
        do_req(0, 32'h10, 1'b1, 1'b0, 64'h0, 0);

        // Outside the window: ignored for ten cycles.
        do_req(0, 32'h0000_1000, 1'b1, 1'b0, 64'h0, 10);

        // Error responses leave memory untouched.
        do_req(0, 32'h08, 1'b0, 1'b1, 64'h0000_0000_0000_1234, 0);
        do_req(0, 32'h0C, 1'b1, 1'b0, 64'h0, 0);
        do_req(0, 32'h08, 1'b1, 1'b1, 64'h0000_0000_0000_0BAD, 0);
        do_req(0, 32'h08, 1'b1, 1'b0, 64'h0, 0);

        // Write aborted one edge into WAIT is never committed.
        do_req(0, 32'h20, 1'b0, 1'b1, 64'h5, 0);
        @(negedge clock); #1;
        which = 0; addr = 32'h20; wr = 1'b1; dval = 64'h1; drv = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock); #1;
        wr = 1'b0; drv = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
            chk("abort_no_ready", 64'(bif_a.ready), 64'd0);
        end
        chk("abort_idle", 64'(bif_a.busy), 64'd0);
        do_req(0, 32'h20, 1'b1, 1'b0, 64'h0, 0);

        // Reset in the middle of a write's wait period.
        do_req(0, 32'h18, 1'b0, 1'b1, 64'h7, 0);
        @(negedge clock); #1;
        which = 0; addr = 32'h18; wr = 1'b1; dval = 64'hFF; drv = 1'b1;
        @(posedge clock); #1;
        chk("wait_busy", 64'(bif_a.busy), 64'd1);
        #2;
        wr = 1'b0; drv = 1'b0; reset = 1'b0;
        #1;
        chk("midreset_ready", 64'(bif_a.ready), 64'd0);
        chk("midreset_busy", 64'(bif_a.busy), 64'd0);
        chk("midreset_bus", data_a, ALL1);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        do_req(0, 32'h18, 1'b1, 1'b0, 64'h0, 0);

        // Zero wait states: back-to-back alternating words, then a held read.
        for (int i = 0; i < 4; i++) begin
            do_req(1, 32'h0, 1'b0, 1'b1, 64'h100 + 64'(i), 0);
            do_req(1, 32'h8, 1'b0, 1'b1, 64'h200 + 64'(i), 0);
        end
        do_req(1, 32'h0, 1'b1, 1'b0, 64'h0, 0);
        do_req(1, 32'h8, 1'b1, 1'b0, 64'h0, 3);

        rand_ops(0, 40);
        rand_ops(1, 40);

        repeat (5) @(posedge clock);
        #1 chk("queue_drained", 64'(exp_a.size() + exp_b.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
